tile_drawer: RTL and testbench

- Parametrised successor to the fixed 2x2 tile lookup.
- Maps a tile index onto a GRID_COLS x GRID_ROWS grid of square tiles, each TILE_W pixels wide.
- Sequences every pixel of the selected tile to the VGA adapter as plot/x/y/colour, one pixel per clock, using a start/busy/done handshake.
- Sits between the game-sequence FSM (which issues a tile to flash or erase) and the VGA adapter's plot port.

---
 rtl/tile_drawer.sv | 201 ++++++++++++++++++++
 tb/tb_tile_drawer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_drawer.sv
// tile_drawer: draws one square tile of a GRID_COLS x GRID_ROWS grid onto the
// VGA adapter plot port, one pixel per clock, in raster order (x fastest).
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start, tile, erase  request; sampled only while idle
//   busy                high from the cycle after acceptance through the done cycle
//   done                one-cycle pulse when the request completes
//   err                 one-cycle pulse with done when the tile index is out of range
//   plot, x, y, colour  VGA write port; colour is 0 whenever plot is low
//
// Optional build macro: TILE_DRAWER_BORDER_EN draws a white outline around
// non-erase tiles.
module tile_drawer #(
  parameter int TILE_W    = 8,
  parameter int GRID_COLS = 2,
  parameter int GRID_ROWS = 2,
  parameter int IDX_W     = 2,
  parameter int COORD_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IDX_W-1:0]   tile,
  input  logic               erase,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               plot,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [2:0]         colour
);

  localparam int unsigned PW     = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned NTILES = GRID_COLS * GRID_ROWS;
  localparam logic [PW-1:0]      PMAX   = PW'(TILE_W - 1);
  localparam logic [COORD_W-1:0] COLS_C = COORD_W'(GRID_COLS);
  localparam logic [COORD_W-1:0] TW_C   = COORD_W'(TILE_W);

`ifdef TILE_DRAWER_BORDER_EN
  localparam logic BORDER_C = 1'b1;
`else
  localparam logic BORDER_C = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      px_q, px_d, py_q, py_d;
  logic [COORD_W-1:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic [2:0]         col_q, col_d;
  logic               erase_q, erase_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d, plot_q, plot_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]         colour_q, colour_d;

  // Request decode, evaluated against the live inputs while idle
  logic [COORD_W-1:0] tile_c, req_bx, req_by;
  logic               tile_ok;
  logic [2:0]         tile_col;

  // Next raster position while drawing
  logic [PW-1:0]      px_n, py_n;
  logic               last_pix, edge_n;

  always_comb begin
    tile_c   = COORD_W'(tile);
    tile_ok  = (32'(tile) < NTILES);
    tile_col = 3'((32'(tile) % 7) + 1);
    req_bx   = (tile_c % COLS_C) * TW_C;
    req_by   = (tile_c / COLS_C) * TW_C;

    last_pix = (px_q == PMAX) && (py_q == PMAX);
    if (px_q == PMAX) begin
      px_n = '0;
      py_n = py_q + 1'b1;
    end else begin
      px_n = px_q + 1'b1;
      py_n = py_q;
    end

`ifdef TILE_DRAWER_BORDER_EN
    edge_n = (px_n == '0) || (px_n == PMAX) || (py_n == '0) || (py_n == PMAX);
`else
    edge_n = 1'b0;
`endif
  end

  // The first pixel is registered on the accepting edge, so plot rises the
  // cycle after start; DRAW then presents (px_q, py_q) and precomputes the next.
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    col_d    = col_q;
    erase_d  = erase_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = '0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          erase_d = erase;
          col_d   = tile_col;
          if (tile_ok) begin
            base_x_d = req_bx;
            base_y_d = req_by;
            px_d     = '0;
            py_d     = '0;
            plot_d   = 1'b1;
            x_d      = req_bx;
            y_d      = req_by;
            colour_d = erase ? 3'b000 : (BORDER_C ? 3'b111 : tile_col);
            state_d  = S_DRAW;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_DRAW: begin
        if (last_pix) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          px_d     = px_n;
          py_d     = py_n;
          plot_d   = 1'b1;
          x_d      = base_x_q + COORD_W'(px_n);
          y_d      = base_y_q + COORD_W'(py_n);
          colour_d = erase_q ? 3'b000 : (edge_n ? 3'b111 : col_q);
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      px_q     <= '0;
      py_q     <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      col_q    <= '0;
      erase_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      col_q    <= col_d;
      erase_q  <= erase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_tile_drawer.sv
// Directed bench for tile_drawer: a default 2x2/8px instance (u_a) and a
// 3x3/4px instance (u_b) share clock and reset.
module tb_tile_drawer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a, erase_a, busy_a, done_a, err_a, plot_a;
  logic [1:0] tile_a;
  logic [7:0] x_a, y_a;
  logic [2:0] colour_a;

  logic       start_b, erase_b, busy_b, done_b, err_b, plot_b;
  logic [3:0] tile_b;
  logic [7:0] x_b, y_b;
  logic [2:0] colour_b;

  tile_drawer u_a (
    .clk(clk), .reset(reset), .start(start_a), .tile(tile_a), .erase(erase_a),
    .busy(busy_a), .done(done_a), .err(err_a), .plot(plot_a),
    .x(x_a), .y(y_a), .colour(colour_a)
  );

  tile_drawer #(.TILE_W(4), .GRID_COLS(3), .GRID_ROWS(3), .IDX_W(4), .COORD_W(8)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .tile(tile_b), .erase(erase_b),
    .busy(busy_b), .done(done_b), .err(err_b), .plot(plot_b),
    .x(x_b), .y(y_b), .colour(colour_b)
  );

  logic       sel;
  logic       m_busy, m_done, m_err, m_plot;
  logic [7:0] m_x, m_y;
  logic [2:0] m_colour;

  always_comb begin
    m_busy   = sel ? busy_b   : busy_a;
    m_done   = sel ? done_b   : done_a;
    m_err    = sel ? err_b    : err_a;
    m_plot   = sel ? plot_b   : plot_a;
    m_x      = sel ? x_b      : x_a;
    m_y      = sel ? y_b      : y_a;
    m_colour = sel ? colour_b : colour_a;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input bit st, input int t, input bit er);
    if (s) begin
      start_b = st; tile_b = 4'(t); erase_b = er;
    end else begin
      start_a = st; tile_a = 2'(t); erase_a = er;
    end
  endtask

  // Issues one request and checks every plotted pixel, the plot/busy counts,
  // the done timing and the quiet cycles afterwards. rep > 0 re-pulses start
  // (with tile 1) on that cycle of the draw.
  task automatic draw(input string tag, input bit s, input int t, input bit er,
                      input int tw, input int bx, input int by, input int col,
                      input int nplots, input bit eerr, input int rep);
    int n, busy_n, done_cyc, white_n, px, py, ec;
    n = 0; busy_n = 0; done_cyc = -1; white_n = 0;
    sel = s;
    drive(s, 1'b1, t, er);
    @(negedge clk);
    drive(s, 1'b0, t, er);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (rep > 0 && cyc == rep)     drive(s, 1'b1, 1, 1'b0);
      if (rep > 0 && cyc == rep + 1) drive(s, 1'b0, t, er);
      if (m_plot) begin
        px = n % tw;
        py = n / tw;
        ec = er ? 0 : col;
`ifdef TILE_DRAWER_BORDER_EN
        if (!er && (px == 0 || px == tw - 1 || py == 0 || py == tw - 1)) ec = 7;
`endif
        check($sformatf("%s x[%0d]", tag, n), m_x, bx + px);
        check($sformatf("%s y[%0d]", tag, n), m_y, by + py);
        check($sformatf("%s colour[%0d]", tag, n), m_colour, ec);
        if (m_colour == 3'b111) white_n++;
        n++;
      end
      if (m_busy) busy_n++;
      if (m_done) begin
        done_cyc = cyc;
        check({tag, " err"}, m_err, eerr);
        check({tag, " plot at done"}, m_plot, 0);
        check({tag, " colour at done"}, m_colour, 0);
        break;
      end
      @(negedge clk);
    end
    check({tag, " plots"}, n, nplots);
    check({tag, " done cycle"}, done_cyc, nplots + 1);
    check({tag, " busy cycles"}, busy_n, nplots + 1);
`ifdef TILE_DRAWER_BORDER_EN
    if (!er && nplots > 0) check({tag, " white pixels"}, white_n, 4 * tw - 4);
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, " post done"}, m_done, 0);
      check({tag, " post plot"}, m_plot, 0);
      check({tag, " post busy"}, m_busy, 0);
      check({tag, " post colour"}, m_colour, 0);
      if (k == 0 && nplots > 0) begin
        check({tag, " hold x"}, m_x, bx + tw - 1);
        check({tag, " hold y"}, m_y, by + tw - 1);
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1;
    sel = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst busy", busy_a, 0);
    check("rst done", done_a, 0);
    check("rst err", err_a, 0);
    check("rst plot", plot_a, 0);
    check("rst x", x_a, 0);
    check("rst y", y_a, 0);
    check("rst colour", colour_a, 0);
    check("rst busy b", busy_b, 0);
    reset = 1'b0;
    @(negedge clk);

    draw("t0",     1'b0, 0, 1'b0, 8, 0, 0, 1, 64, 1'b0, 0);
    draw("t3",     1'b0, 3, 1'b0, 8, 8, 8, 4, 64, 1'b0, 0);
    draw("t2 ers", 1'b0, 2, 1'b1, 8, 0, 8, 0, 64, 1'b0, 0);
    draw("t1",     1'b0, 1, 1'b0, 8, 8, 0, 2, 64, 1'b0, 0);
    draw("b t5",   1'b1, 5, 1'b0, 4, 8, 4, 6, 16, 1'b0, 0);
    draw("b t9",   1'b1, 9, 1'b0, 4, 0, 0, 0, 0,  1'b1, 0);
    draw("repulse", 1'b0, 0, 1'b0, 8, 0, 0, 1, 64, 1'b0, 10);

    // Reset while the 20th pixel of tile 1 is on the port
    sel = 1'b0;
    n = 0;
    drive(1'b0, 1'b1, 1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1, 1'b0);
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (plot_a) n++;
      if (n == 20) break;
      @(negedge clk);
    end
    check("midrst reached plot 20", n, 20);
    reset = 1'b1;
    #1;
    check("midrst plot", plot_a, 0);
    check("midrst busy", busy_a, 0);
    check("midrst done", done_a, 0);
    check("midrst x", x_a, 0);
    check("midrst y", y_a, 0);
    check("midrst colour", colour_a, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst no done", done_a, 0);
      check("midrst no plot", plot_a, 0);
    end
    draw("t1 redo", 1'b0, 1, 1'b0, 8, 8, 0, 2, 64, 1'b0, 0);

    // start held high: after done, one idle cycle, then a fresh draw
    sel = 1'b0;
    seen = 1'b0;
    drive(1'b0, 1'b1, 0, 1'b0);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    check("held first done", seen, 1);
    @(negedge clk);
    check("held gap busy", busy_a, 0);
    check("held gap plot", plot_a, 0);
    @(negedge clk);
    check("held restart plot", plot_a, 1);
    check("held restart x", x_a, 0);
    check("held restart y", y_a, 0);
    drive(1'b0, 1'b0, 0, 1'b0);
    seen = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    check("held second done", seen, 1);
    @(negedge clk);
    check("held final busy", busy_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
